// File: rtl/serial_sub_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl_if
// Handshake and result bundle for the bit-serial subtractor.
//   start      : request a subtraction (master -> slave)
//   a, b       : minuend / subtrahend, captured on accept (master -> slave)
//   busy       : operation in progress (slave -> master)
//   done       : one-cycle result-valid pulse (slave -> master)
//   diff       : a - b modulo 2^WIDTH (slave -> master)
//   borrow_out : final borrow, 1 when unsigned a < b (slave -> master)
//   overflow   : signed overflow flag, only with SERIAL_SUB_OVF_EN defined
// Optional feature macro: SERIAL_SUB_OVF_EN
// -----------------------------------------------------------------------------
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , input overflow
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
`ifdef SERIAL_SUB_OVF_EN
        , output overflow
`endif
    );
endinterface

// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a
// single full-subtractor cell (sub_full) whose carry terminals carry the borrow.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all state)
//   bus   : serial_sub_ctrl_if.slave (start/a/b in; busy/done/diff/
//           borrow_out[/overflow] out)
// Parameter WIDTH : operand width, 2..64.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed overflow flag.
// -----------------------------------------------------------------------------

// One-bit full subtractor: sub = a - b - carry_in, carry_out = borrow out.
module sub_full (
    output logic sub,
    output logic carry_out,
    input  logic a,
    input  logic b,
    input  logic carry_in
);
    always_comb begin
        sub       = a ^ b ^ carry_in;
        carry_out = (~a & b) | (~(a ^ b) & carry_in);
    end
endmodule

module serial_sub_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_sub_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             brw_q, brw_d;
    logic             borrow_out_q, borrow_out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_SUB_OVF_EN
    // Operand MSBs are kept aside because the shift registers lose them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic cell_sub;
    logic cell_cout;

    sub_full u_cell (
        .sub       (cell_sub),
        .carry_out (cell_cout),
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .carry_in  (brw_q)
    );

    always_comb begin
        state_d      = state_q;
        a_sh_d       = a_sh_q;
        b_sh_d       = b_sh_q;
        res_d        = res_q;
        diff_d       = diff_q;
        brw_d        = brw_q;
        borrow_out_d = borrow_out_q;
        cnt_d        = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        ovf_d        = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                // New bit enters at the MSB; after WIDTH shifts the first
                // (LSB) result bit has walked down to bit 0.
                res_d  = {cell_sub, res_q[WIDTH-1:1]};
                brw_d  = cell_cout;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d      = DONE;
                    diff_d       = {cell_sub, res_q[WIDTH-1:1]};
                    borrow_out_d = cell_cout;
`ifdef SERIAL_SUB_OVF_EN
                    // cell_sub is the MSB of the final difference.
                    ovf_d = (a_msb_q != b_msb_q) && (cell_sub != a_msb_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_sh_q       <= '0;
            b_sh_q       <= '0;
            res_q        <= '0;
            diff_q       <= '0;
            brw_q        <= 1'b0;
            borrow_out_q <= 1'b0;
            cnt_q        <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_sh_q       <= a_sh_d;
            b_sh_q       <= b_sh_d;
            res_q        <= res_d;
            diff_q       <= diff_d;
            brw_q        <= brw_d;
            borrow_out_q <= borrow_out_d;
            cnt_q        <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
// Directed bench for serial_sub_ctrl at WIDTH=8 with a result scoreboard.
// Honours SERIAL_SUB_OVF_EN when defined.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] d;
        logic         br;
        logic         ov;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   ndone;
    logic [W-1:0] prev_diff;
    exp_t sb[$];

    serial_sub_ctrl_if #(.WIDTH(W)) bus ();

    serial_sub_ctrl #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.d  = a - b;
        e.br = (a < b);
        e.ov = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            exp_t e;
            ndone++;
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("diff", 64'(bus.diff), 64'(e.d));
                chk("borrow_out", 64'(bus.borrow_out), 64'(e.br));
`ifdef SERIAL_SUB_OVF_EN
                chk("overflow", 64'(bus.overflow), 64'(e.ov));
`endif
                prev_diff = e.d;
            end
        end
    end

    // One operation: called #1 after a rising edge while the DUT is idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            @(posedge clk);
            #1;
            chk("busy_run", 64'(bus.busy), 64'd1);
            chk("done_timing", 64'(bus.done), 64'(k == W));
            if (k < W) chk("diff_hold", 64'(bus.diff), 64'(prev_diff));
            if (k == 3) begin
                bus.a = W'($urandom);
                bus.b = W'($urandom);
            end
        end
        @(posedge clk);
        #1;
        chk("busy_idle", 64'(bus.busy), 64'd0);
        chk("done_low", 64'(bus.done), 64'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        ndone     = 0;
        prev_diff = '0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #2;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_diff", 64'(bus.diff), 64'd0);
        chk("rst_borrow", 64'(bus.borrow_out), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'h05, 8'h03);
        run_op(8'h03, 8'h05);
        run_op(8'h80, 8'h01);
        run_op(8'h7F, 8'hFF);
        run_op(8'hFF, 8'h00);

        // Abort during RUN: accept, four RUN edges, then reset mid-cycle.
        bus.start = 1'b1;
        bus.a     = 8'h12;
        bus.b     = 8'h34;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_diff", 64'(bus.diff), 64'd0);
        chk("abort_borrow", 64'(bus.borrow_out), 64'd0);
        prev_diff = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 64'(bus.done), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_abort_idle", 64'(bus.busy), 64'd0);
        run_op(8'h00, 8'h01);

        // Held start: accepts at relative edges 0, 10, 20.
        sb.push_back(model(8'h10, 8'h20));
        sb.push_back(model(8'hC3, 8'h3C));
        sb.push_back(model(8'h01, 8'h80));
        ndone     = 0;
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h20;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (k == 1)  begin bus.a = 8'hC3; bus.b = 8'h3C; end
            if (k == 11) begin bus.a = 8'h01; bus.b = 8'h80; end
            if (k == 29) bus.start = 1'b0;
            chk("held_done", 64'(bus.done), 64'((k % 10) == 8));
            chk("held_busy", 64'(bus.busy), 64'(((k % 10) != 9) && (k != 30)));
        end
        repeat (3) @(posedge clk);
        #1;
        chk("held_done_count", 64'(ndone), 64'd3);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand width in bits, legal range 2..64.
REQ-002 Port clk input 1: single clock; all state changes on its rising edge.
REQ-003 Port rst_n input 1: asynchronous, active-low reset.
REQ-004 Port start input 1: request a subtraction; sampled only in IDLE.
REQ-005 Port a input WIDTH: minuend; captured when start is accepted.
REQ-006 Port b input WIDTH: subtrahend; captured when start is accepted.
REQ-007 Port busy output 1: high while in RUN or DONE.
REQ-008 Port done output 1: one-cycle pulse; result is valid.
REQ-009 Port diff output WIDTH: a - b modulo 2^WIDTH.
REQ-010 Port borrow_out output 1: final borrow; 1 when unsigned a < b.
REQ-011 Port overflow output 1: signed overflow flag; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-012 The block SHALL instantiate exactly one sub_full cell, port order (sub, carry_out, a, b, carry_in), and SHALL compute the result one bit per cycle, LSB first.
REQ-013 The sub_full carry_in SHALL act as borrow-in and carry_out as borrow-out.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN when start=1.
- RUN -> DONE after WIDTH bit-cycles.
- DONE -> IDLE unconditionally.
REQ-015 On start accept (edge 0):
- a and b SHALL load into shift registers.
- The borrow register SHALL clear to 0.
- The bit counter SHALL clear to 0.
REQ-016 At each RUN edge n (n=1..WIDTH), the block SHALL:
- write the cell's sub output into diff bit n-1 via a right-shifting result register;
- store carry_out into the borrow register;
- shift both operand registers right by one;
- increment the counter.
REQ-017 The cell inputs SHALL be the operand-register LSBs and the borrow register.
REQ-018 The counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap during an operation; the RUN exit condition is counter == WIDTH-1 at the sampling edge.
REQ-019 Latency: done SHALL be high exactly in the cycle after edge WIDTH, i.e. WIDTH+1 cycles after the start-accept edge.
REQ-020 done SHALL be high for exactly one cycle, while in DONE.
REQ-021 start SHALL be ignored in RUN and in DONE; a held start is re-accepted in IDLE, giving a minimum issue interval of WIDTH+2 cycles.
REQ-022 diff and borrow_out SHALL update only at edge WIDTH and SHALL hold their values until the next operation's edge WIDTH.
REQ-023 Changes to a and b after the accept edge SHALL NOT affect the result.

Reset
REQ-024 On rst_n=0, immediately and independent of clk, the block SHALL:
- enter IDLE;
- drive busy=0 and done=0;
- clear diff, borrow_out and overflow to 0;
- clear the counter, operand registers and borrow register.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst_n rises SHALL be processed normally.

Configuration
REQ-026 Macro SERIAL_SUB_OVF_EN: when defined, overflow SHALL exist and SHALL update at edge WIDTH to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands; it SHALL hold like diff.
REQ-027 When SERIAL_SUB_OVF_EN is undefined, the overflow port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification (WIDTH=8)
REQ-028 a=0x05, b=0x03, start pulse -> done 9 cycles after accept, diff=0x02, borrow_out=0, overflow=0.
REQ-029 a=0x03, b=0x05 -> diff=0xFE, borrow_out=1, overflow=0.
REQ-030 a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1 (only with SERIAL_SUB_OVF_EN).
REQ-031 Accept a=0xFF, b=0x00; pulse start and change a, b at cycle 3 -> single done, diff=0xFF, borrow_out=0.
REQ-032 rst_n=0 at cycle 4 of RUN -> busy=0 and diff=0x00 at once, no done; then a=0x00, b=0x01 -> diff=0xFF, borrow_out=1.
REQ-033 start held high for 30 cycles -> done pulses exactly 10 cycles apart, busy low for exactly one cycle between operations.
